tag_pool_ctrl: RTL and testbench
================================

TAG_POOL_CTRL -- requirements
Module: tag_pool_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 5, meaning tag width in bits.
REQ-002 SHALL have parameter NTAGS, default 32, meaning pool depth (= 1<<DSIZE).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester tag request level (bit0 = requester 0).
REQ-006 SHALL have port gnt  output  2  one-hot, one-cycle grant pulse.
REQ-007 SHALL have port gnt_tag  output  DSIZE  tag delivered with gnt.
REQ-008 SHALL have port ret_valid  input  2  per-source tag return strobe.
REQ-009 SHALL have port ret_tag0 / ret_tag1  input  DSIZE each  returned tag values.
REQ-010 SHALL have port ret_rdy  output  2  return accepted this cycle, combinational.
REQ-011 SHALL have port free_cnt  output  DSIZE+1  tags currently in pool, 0..NTAGS.
REQ-012 SHALL have port init_done  output  1  high once the pool is filled after reset.
REQ-013 SHALL have port ovf_err  output  1  sticky: return attempted while pool full.

Function
REQ-014 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-015 In INIT: push tag values 0,1,...,NTAGS-1, one per cycle; after the push of NTAGS-1, go to RUN and set init_done; the transition takes exactly NTAGS cycles.
REQ-016 In INIT: gnt SHALL be 0 and ret_rdy SHALL be 0; req and ret_valid are ignored.
REQ-017 In RUN: at most one pop per cycle; a pop is eligible when req!=0 and free_cnt!=0.
REQ-018 Arbitration SHALL be round-robin with a 1-bit last-winner pointer: if both request, the requester not granted most recently wins; a single requester always wins; the pointer updates only on a grant.
REQ-019 Grant latency: req sampled at edge N; gnt and gnt_tag registered, valid for exactly the cycle after edge N; gnt_tag = head of pool at edge N; pop occurs at edge N.
REQ-020 A requester holding req high SHALL receive a further grant per arbitration win; the requester drops req the cycle it sees gnt.
REQ-021 In RUN: at most one push per cycle; ret_valid[0] has fixed priority over ret_valid[1]; ret_rdy[i] = ret_valid[i] & selected & not full, where full means free_cnt==NTAGS with no same-cycle pop.
REQ-022 An unaccepted return is held by the source (ret_valid and tag stable) until ret_rdy.
REQ-023 When ret_valid!=0 and the pool is full with no pop, no push occurs and ovf_err SHALL set and stay set until reset.
REQ-024 free_cnt arithmetic: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop; never wraps below 0 or above NTAGS.
REQ-025 Simultaneous push and pop with free_cnt==0: pop SHALL NOT occur (returned tag not bypassed); push occurs.
REQ-026 Pool order SHALL be FIFO: tags are granted in the order pushed.

Reset
REQ-027 Asserting rst_n low at any time, including mid-INIT or mid-grant, SHALL asynchronously clear: gnt=0, gnt_tag=0, free_cnt=0, init_done=0, ovf_err=0, rr pointer=0, FSM=INIT, pool pointers=0.
REQ-028 After deassertion the full INIT sequence of REQ-015 SHALL rerun; no tag issued before reset is assumed still allocated.

Structure
REQ-029 DSIZE, NTAGS and the FSM state encoding SHALL live in the shared project package.
REQ-030 Pool storage SHALL be one instance of the existing single-clock-usable fifo block (DSIZE=DSIZE, ASIZE=NTAGS-1), both clock ports tied to clk and both resets to rst_n; the controller drives winc/wdata/rinc and reads rdata; full/empty decisions use free_cnt.
REQ-031 No further sub-modules; arbiter and FSM live in tag_pool_ctrl.

Verification
REQ-032 Reset release, no traffic -> init_done rises 32 cycles later, free_cnt=32, gnt stays 0 throughout.
REQ-033 After init, req=2'b11 held 4 cycles -> gnt sequence 01,10,01,10 with gnt_tag 0,1,2,3; free_cnt=28.
REQ-034 Drain all 32 tags then req=2'b01 -> no gnt; ret_valid=2'b01, ret_tag0=7 -> ret_rdy=01, next cycle free_cnt=1, following grant gnt_tag=7.
REQ-035 free_cnt=32, ret_valid=2'b10, ret_tag1=3 -> ret_rdy=0, ovf_err=1 sticky, free_cnt stays 32.
REQ-036 free_cnt=10, req=01 and ret_valid=11 same cycle -> one grant, ret_rdy=01, free_cnt stays 10; next cycle ret_rdy=10 accepted, free_cnt=11.
REQ-037 rst_n pulsed low at INIT cycle 15 -> all outputs zero immediately; INIT restarts at tag 0 and completes 32 cycles after release.

Source files
------------

// File: rtl/tag_pool_ctrl_pkg.sv
// Shared constants and state encoding for the tag pool controller.
package tag_pool_ctrl_pkg;

    localparam int unsigned DSIZE = 5;
    localparam int unsigned NTAGS = 1 << DSIZE;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/tag_pool_ctrl_fifo.sv
// Fall-through FIFO holding the free tags; rdata always shows the head entry.
// ASIZE is the highest storage index, so the depth is ASIZE+1.
module tag_pool_ctrl_fifo #(
    parameter int unsigned DSIZE = 5,
    parameter int unsigned ASIZE = 31
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata
);

    localparam int unsigned AW = (ASIZE > 0) ? $clog2(ASIZE + 1) : 1;

    logic [DSIZE-1:0] mem [0:ASIZE];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;

    always_ff @(posedge wclk) begin
        if (winc) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr_q <= '0;
        end else if (winc) begin
            wptr_q <= (wptr_q == AW'(ASIZE)) ? '0 : wptr_q + 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_q <= '0;
        end else if (rinc) begin
            rptr_q <= (rptr_q == AW'(ASIZE)) ? '0 : rptr_q + 1'b1;
        end
    end

    assign rdata = mem[rptr_q];

endmodule

// File: rtl/tag_pool_ctrl.sv
// Tag pool controller: fills the pool after reset, then grants tags round-robin
// to two requesters and accepts returned tags with source 0 taking priority.
module tag_pool_ctrl
    import tag_pool_ctrl_pkg::*;
#(
    parameter int unsigned DSIZE = tag_pool_ctrl_pkg::DSIZE,
    parameter int unsigned NTAGS = tag_pool_ctrl_pkg::NTAGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [DSIZE-1:0] gnt_tag,
    input  logic [1:0]       ret_valid,
    input  logic [DSIZE-1:0] ret_tag0,
    input  logic [DSIZE-1:0] ret_tag1,
    output logic [1:0]       ret_rdy,
    output logic [DSIZE:0]   free_cnt,
    output logic             init_done,
    output logic             ovf_err
);

    state_e           state_q, state_d;
    logic [DSIZE-1:0] init_cnt_q;
    logic [DSIZE:0]   free_cnt_q, free_cnt_d;
    logic             rr_q, rr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [DSIZE-1:0] gnt_tag_q, gnt_tag_d;
    logic             ovf_err_q, set_ovf;
    logic             pop, push, winner, full;
    logic             winc;
    logic [DSIZE-1:0] wdata, rdata;

    assign full = (free_cnt_q == (DSIZE + 1)'(NTAGS));

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        push      = 1'b0;
        winner    = rr_q;
        rr_d      = rr_q;
        ret_rdy   = 2'b00;
        winc      = 1'b0;
        wdata     = init_cnt_q;
        set_ovf   = 1'b0;
        gnt_d     = 2'b00;
        gnt_tag_d = '0;

        unique case (state_q)
            StInit: begin
                push = 1'b1;
                winc = 1'b1;
                if (init_cnt_q == DSIZE'(NTAGS - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // rr_q names the requester that wins a tie.
                winner = (req == 2'b11) ? rr_q : req[1];
                pop    = (req != 2'b00) && (free_cnt_q != '0);
                if (ret_valid != 2'b00) begin
                    if (!full || pop) begin
                        push    = 1'b1;
                        winc    = 1'b1;
                        wdata   = ret_valid[0] ? ret_tag0 : ret_tag1;
                        ret_rdy = ret_valid[0] ? 2'b01 : 2'b10;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                if (pop) begin
                    gnt_d     = winner ? 2'b10 : 2'b01;
                    gnt_tag_d = rdata;
                    rr_d      = ~winner;
                end
            end
        endcase

        unique case ({push, pop})
            2'b10:   free_cnt_d = free_cnt_q + 1'b1;
            2'b01:   free_cnt_d = free_cnt_q - 1'b1;
            default: free_cnt_d = free_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            free_cnt_q <= '0;
            rr_q       <= 1'b0;
            gnt_q      <= 2'b00;
            gnt_tag_q  <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= (state_q == StInit) ? init_cnt_q + 1'b1 : '0;
            free_cnt_q <= free_cnt_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            gnt_tag_q  <= gnt_tag_d;
            ovf_err_q  <= ovf_err_q | set_ovf;
        end
    end

    tag_pool_ctrl_fifo #(
        .DSIZE(DSIZE),
        .ASIZE(NTAGS - 1)
    ) u_fifo (
        .wclk  (clk),
        .wrst_n(rst_n),
        .winc  (winc),
        .wdata (wdata),
        .rclk  (clk),
        .rrst_n(rst_n),
        .rinc  (pop),
        .rdata (rdata)
    );

    assign gnt       = gnt_q;
    assign gnt_tag   = gnt_tag_q;
    assign free_cnt  = free_cnt_q;
    assign init_done = (state_q == StRun);
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_tag_pool_ctrl.sv
// Directed bench for tag_pool_ctrl: init fill, arbitration, returns, overflow, reset.
module tb_tag_pool_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [4:0] gnt_tag;
    logic [1:0] ret_valid;
    logic [4:0] ret_tag0;
    logic [4:0] ret_tag1;
    logic [1:0] ret_rdy;
    logic [5:0] free_cnt;
    logic       init_done;
    logic       ovf_err;

    int errors = 0;
    int checks = 0;

    tag_pool_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_tag  (gnt_tag),
        .ret_valid(ret_valid),
        .ret_tag0 (ret_tag0),
        .ret_tag1 (ret_tag1),
        .ret_rdy  (ret_rdy),
        .free_cnt (free_cnt),
        .init_done(init_done),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, ".gnt"}, 32'(gnt), 0);
        chk({name, ".gnt_tag"}, 32'(gnt_tag), 0);
        chk({name, ".free_cnt"}, 32'(free_cnt), 0);
        chk({name, ".init_done"}, 32'(init_done), 0);
        chk({name, ".ovf_err"}, 32'(ovf_err), 0);
        chk({name, ".ret_rdy"}, 32'(ret_rdy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        ret_valid = 2'b00;
        ret_tag0 = '0;
        ret_tag1 = '0;
        tick();
        tick();
        chk_zero_outputs("reset");

        // Init fill with no traffic: 32 edges, counting up, no grants.
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("init.free_cnt", 32'(free_cnt), 32'(i));
            chk("init.init_done", 32'(init_done), (i == 32) ? 1 : 0);
            chk("init.gnt", 32'(gnt), 0);
        end

        // Both requesting: alternate starting with requester 0, tags in order.
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr.gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr.gnt_tag", 32'(gnt_tag), 32'(i));
            chk("rr.free_cnt", 32'(free_cnt), 32'(31 - i));
        end
        req = 2'b00;
        tick();
        chk("rr_idle.gnt", 32'(gnt), 0);
        chk("rr_idle.free_cnt", 32'(free_cnt), 28);

        // Drain the remaining 28 tags through requester 0.
        req = 2'b01;
        for (int i = 0; i < 28; i++) begin
            tick();
            chk("drain.gnt", 32'(gnt), 1);
            chk("drain.gnt_tag", 32'(gnt_tag), 32'(4 + i));
        end
        tick();
        chk("empty.gnt", 32'(gnt), 0);
        chk("empty.free_cnt", 32'(free_cnt), 0);

        // Return into an empty pool with a pending request: no bypass.
        ret_valid = 2'b01;
        ret_tag0 = 5'd7;
        #1;
        chk("ret_empty.ret_rdy", 32'(ret_rdy), 1);
        tick();
        ret_valid = 2'b00;
        chk("ret_empty.free_cnt", 32'(free_cnt), 1);
        chk("ret_empty.gnt", 32'(gnt), 0);
        tick();
        req = 2'b00;
        chk("regrant.gnt", 32'(gnt), 1);
        chk("regrant.gnt_tag", 32'(gnt_tag), 7);
        chk("regrant.free_cnt", 32'(free_cnt), 0);

        // Refill to 10 with tags 20..29 via source 0.
        for (int i = 0; i < 10; i++) begin
            ret_valid = 2'b01;
            ret_tag0 = 5'(20 + i);
            #1;
            chk("refill.ret_rdy", 32'(ret_rdy), 1);
            tick();
            chk("refill.free_cnt", 32'(free_cnt), 32'(i + 1));
        end
        ret_valid = 2'b00;

        // Pop plus dual return: source 0 first, source 1 next cycle.
        req = 2'b01;
        ret_valid = 2'b11;
        ret_tag0 = 5'd5;
        ret_tag1 = 5'd6;
        #1;
        chk("dual.ret_rdy0", 32'(ret_rdy), 1);
        tick();
        chk("dual.gnt", 32'(gnt), 1);
        chk("dual.gnt_tag", 32'(gnt_tag), 20);
        chk("dual.free_cnt0", 32'(free_cnt), 10);
        req = 2'b00;
        ret_valid = 2'b10;
        #1;
        chk("dual.ret_rdy1", 32'(ret_rdy), 2);
        tick();
        ret_valid = 2'b00;
        chk("dual.free_cnt1", 32'(free_cnt), 11);
        chk("dual.gnt_idle", 32'(gnt), 0);

        // Last winner was requester 0, so a tie now goes to requester 1.
        req = 2'b11;
        tick();
        req = 2'b00;
        chk("rr2.gnt", 32'(gnt), 2);
        chk("rr2.gnt_tag", 32'(gnt_tag), 21);
        chk("rr2.free_cnt", 32'(free_cnt), 10);

        // Fill to full via source 1.
        for (int i = 0; i < 22; i++) begin
            ret_valid = 2'b10;
            ret_tag1 = 5'(i);
            #1;
            chk("fill.ret_rdy", 32'(ret_rdy), 2);
            tick();
        end
        chk("fill.free_cnt", 32'(free_cnt), 32);

        // Return while full and no pop: rejected, overflow is sticky.
        ret_tag1 = 5'd3;
        #1;
        chk("ovf.ret_rdy", 32'(ret_rdy), 0);
        chk("ovf.pre", 32'(ovf_err), 0);
        tick();
        ret_valid = 2'b00;
        chk("ovf.set", 32'(ovf_err), 1);
        chk("ovf.free_cnt", 32'(free_cnt), 32);
        tick();
        chk("ovf.sticky", 32'(ovf_err), 1);
        chk("ovf.free_hold", 32'(free_cnt), 32);

        // Full pool with a same-cycle pop accepts the return.
        req = 2'b01;
        ret_valid = 2'b01;
        ret_tag0 = 5'd9;
        #1;
        chk("fullpop.ret_rdy", 32'(ret_rdy), 1);
        tick();
        chk("fullpop.gnt", 32'(gnt), 1);
        chk("fullpop.gnt_tag", 32'(gnt_tag), 22);
        chk("fullpop.free_cnt", 32'(free_cnt), 32);

        // Asynchronous reset while a grant is on the outputs.
        req = 2'b00;
        ret_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_mid_gnt");
        tick();
        rst_n = 1'b1;

        // Traffic during INIT is ignored; reset again at INIT cycle 15.
        req = 2'b11;
        ret_valid = 2'b11;
        for (int i = 1; i <= 15; i++) begin
            #1;
            chk("init_traffic.ret_rdy", 32'(ret_rdy), 0);
            tick();
            chk("init_traffic.gnt", 32'(gnt), 0);
            chk("init_traffic.free_cnt", 32'(free_cnt), 32'(i));
        end
        rst_n = 1'b0;
        req = 2'b00;
        ret_valid = 2'b00;
        #1;
        chk_zero_outputs("rst_mid_init");
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("reinit.free_cnt", 32'(free_cnt), 32'(i));
            chk("reinit.init_done", 32'(init_done), (i == 32) ? 1 : 0);
        end
        chk("reinit.ovf_err", 32'(ovf_err), 0);

        // Pool restarts at tag 0 and the pointer favours requester 0 again.
        req = 2'b11;
        tick();
        req = 2'b00;
        chk("reinit.gnt", 32'(gnt), 1);
        chk("reinit.gnt_tag", 32'(gnt_tag), 0);
        chk("reinit.free_after", 32'(free_cnt), 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
